// File: rtl/packet_framer.sv
// Packet framer: registers upstream beats toward a packet FIFO and rolls back any
// packet that carries an error, runs past MAXLEN, or closes shorter than MINLEN.
module packet_framer #(
    parameter int WIDTH  = 8,
    parameter int MAXLEN = 1024,
    parameter int MINLEN = 1,
    parameter int LBITS  = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic             s_tlast,
    input  logic             s_terror,
    input  logic [WIDTH-1:0] s_tdata,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             last_o,
    output logic             drop_o,
    output logic [WIDTH-1:0] data_o,
    output logic [15:0]      count_ok_o,
    output logic [15:0]      count_drop_o,
    output logic [1:0]       state_o
);

    // Handshake: a beat moves upstream on s_tvalid && s_tready and downstream on
    // valid_o && ready_i; data_o/last_o never change while valid_o && !ready_i.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BODY    = 2'd1,
        ST_DROP    = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [LBITS-1:0]   r_count;
    logic [LBITS-1:0]   w_beat_cnt;
    logic               r_valid;
    logic               r_last;
    logic [WIDTH-1:0]   r_data;
    logic               r_drop_last;
    logic [15:0]        r_count_ok;
    logic [15:0]        r_count_drop;
    logic               w_accept;
    logic               w_open;
    logic               w_offend;
    logic               w_fwd;
    logic               w_push_out;
    logic               w_drop;
    logic               w_tready;

    assign w_accept   = s_tvalid && w_tready;
    assign w_open     = (r_state == ST_IDLE) || (r_state == ST_BODY);
    assign w_beat_cnt = r_count + 1'b1;
    assign w_offend   = s_terror
                     || (w_beat_cnt > LBITS'(MAXLEN))
                     || (s_tlast && (w_beat_cnt < LBITS'(MINLEN)));
    assign w_fwd      = w_open && w_accept && !w_offend;
    assign w_push_out = r_valid && ready_i;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_BODY: begin
                if (w_accept) begin
                    if (w_offend)     w_state_next = ST_DROP;
                    else if (s_tlast) w_state_next = ST_IDLE;
                    else              w_state_next = ST_BODY;
                end
            end
            // Rollback waits until earlier beats of the packet have left the output stage.
            ST_DROP: begin
                if (!r_valid) w_state_next = r_drop_last ? ST_IDLE : ST_DISCARD;
            end
            ST_DISCARD: begin
                if (w_accept && s_tlast) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_tready = 1'b0;
        w_drop   = 1'b0;
        case (r_state)
            ST_IDLE, ST_BODY: w_tready = !r_valid || ready_i;
            ST_DISCARD:       w_tready = 1'b1;
            ST_DROP:          w_drop   = !r_valid && !reset;
            default:          w_tready = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid      <= 1'b0;
            r_last       <= 1'b0;
            r_data       <= '0;
            r_count      <= '0;
            r_drop_last  <= 1'b0;
            r_count_ok   <= '0;
            r_count_drop <= '0;
        end else begin
            if (w_fwd) begin
                r_valid <= 1'b1;
                r_data  <= s_tdata;
                r_last  <= s_tlast;
            end else if (w_push_out) begin
                r_valid <= 1'b0;
            end
            if (w_open && w_accept && w_offend) r_drop_last <= s_tlast;
            if (w_state_next == ST_IDLE) begin
                r_count <= '0;
            end else if (w_open && w_accept) begin
                r_count <= w_beat_cnt;
            end
            if (w_push_out && r_last && (r_count_ok != 16'hFFFF)) r_count_ok <= r_count_ok + 16'd1;
            if (w_drop && (r_count_drop != 16'hFFFF)) r_count_drop <= r_count_drop + 16'd1;
        end
    end

    assign s_tready     = w_tready;
    assign valid_o      = r_valid;
    assign last_o       = r_last;
    assign data_o       = r_data;
    assign drop_o       = w_drop;
    assign count_ok_o   = r_count_ok;
    assign count_drop_o = r_count_drop;
    assign state_o      = r_state;

endmodule

// File: tb/tb_packet_framer.sv
// Directed bench for packet_framer built with MAXLEN=4, MINLEN=2 so length limits are reachable.
module tb_packet_framer;

    logic        clock = 1'b0;
    logic        reset;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic        s_terror;
    logic [7:0]  s_tdata;
    logic        valid_o;
    logic        ready_i;
    logic        last_o;
    logic        drop_o;
    logic [7:0]  data_o;
    logic [15:0] count_ok_o;
    logic [15:0] count_drop_o;
    logic [1:0]  state_o;

    int checks = 0;
    int errors = 0;
    int drop_seen = 0;
    int drop_bad = 0;
    int cycle = 0;
    int exp_ok = 0;
    int exp_drop = 0;
    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];

    packet_framer #(.WIDTH(8), .MAXLEN(4), .MINLEN(2), .LBITS(12)) dut (
        .clock(clock), .reset(reset),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .s_terror(s_terror), .s_tdata(s_tdata),
        .valid_o(valid_o), .ready_i(ready_i), .last_o(last_o), .drop_o(drop_o),
        .data_o(data_o), .count_ok_o(count_ok_o), .count_drop_o(count_drop_o),
        .state_o(state_o)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle++;

    always @(negedge clock) begin
        if (!reset && valid_o && ready_i) got_q.push_back({last_o, data_o});
        if (drop_o) begin
            drop_seen++;
            if (valid_o) drop_bad++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drive_beat(input logic [7:0] d, input logic l, input logic e);
        int n;
        n = 0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        s_terror = e;
        @(negedge clock);
        while (s_tready !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (s_tready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: s_tready=%b expected 1", s_tready);
        end
        @(posedge clock);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_terror = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_terror = 1'b0; s_tdata = '0;
        ready_i = 1'b1;
        idle(3);
        @(negedge clock);
        checks++;
        if ({valid_o, drop_o, last_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: valid/drop/last=%b expected 000", {valid_o, drop_o, last_o});
        end
        checks++;
        if (count_ok_o !== 16'd0 || count_drop_o !== 16'd0) begin
            errors++;
            $display("FAIL reset_counters: ok=%0d drop=%0d expected 0 0", count_ok_o, count_drop_o);
        end
        checks++;
        if (state_o !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d expected 0", state_o);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_ok = 0;
        exp_drop = 0;
        @(negedge clock);
        checks++;
        if (s_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_tready: got %b expected 1", s_tready);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_basic();
        int d0;
        d0 = drop_seen;
        got_q.delete(); exp_q.delete();
        exp_q = '{9'h011, 9'h012, 9'h013, 9'h114};
        drive_beat(8'h11, 1'b0, 1'b0);
        checks++;
        if (valid_o !== 1'b1 || data_o !== 8'h11) begin
            errors++;
            $display("FAIL basic_latency: valid=%b data=%h expected 1 11", valid_o, data_o);
        end
        drive_beat(8'h12, 1'b0, 1'b0);
        drive_beat(8'h13, 1'b0, 1'b0);
        drive_beat(8'h14, 1'b1, 1'b0);
        idle(4);
        exp_ok++;
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL basic_beats: got %0d beats expected %0d", got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL basic_beat%0d: got %h expected %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (count_ok_o !== 16'(exp_ok) || drop_seen != d0) begin
            errors++;
            $display("FAIL basic_counts: ok=%0d drops=%0d expected %0d 0", count_ok_o, drop_seen - d0, exp_ok);
        end
    endtask

    task automatic test_error();
        int d0;
        int b0;
        d0 = drop_seen;
        b0 = drop_bad;
        got_q.delete(); exp_q.delete();
        exp_q = '{9'h0a1, 9'h0a2, 9'h0b1, 9'h1b2};
        drive_beat(8'ha1, 1'b0, 1'b0);
        drive_beat(8'ha2, 1'b0, 1'b0);
        drive_beat(8'ha3, 1'b0, 1'b1);
        drive_beat(8'ha4, 1'b0, 1'b0);
        drive_beat(8'ha5, 1'b1, 1'b0);
        drive_beat(8'hb1, 1'b0, 1'b0);
        drive_beat(8'hb2, 1'b1, 1'b0);
        idle(4);
        exp_drop++;
        exp_ok++;
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL error_beats: got %0d beats expected %0d", got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL error_beat%0d: got %h expected %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (drop_seen - d0 != 1 || drop_bad != b0) begin
            errors++;
            $display("FAIL error_drop_pulse: pulses=%0d with_valid=%0d expected 1 0", drop_seen - d0, drop_bad - b0);
        end
        checks++;
        if (count_drop_o !== 16'(exp_drop) || count_ok_o !== 16'(exp_ok)) begin
            errors++;
            $display("FAIL error_counts: ok=%0d drop=%0d expected %0d %0d", count_ok_o, count_drop_o, exp_ok, exp_drop);
        end
    endtask

    task automatic test_maxlen();
        int d0;
        d0 = drop_seen;
        got_q.delete(); exp_q.delete();
        exp_q = '{9'h0c1, 9'h0c2, 9'h0c3, 9'h1c4, 9'h0d1, 9'h0d2, 9'h0d3, 9'h0d4};
        drive_beat(8'hc1, 1'b0, 1'b0);
        drive_beat(8'hc2, 1'b0, 1'b0);
        drive_beat(8'hc3, 1'b0, 1'b0);
        drive_beat(8'hc4, 1'b1, 1'b0);
        for (int i = 1; i <= 6; i++) drive_beat(8'hd0 + 8'(i), (i == 6), 1'b0);
        idle(4);
        exp_ok++;
        exp_drop++;
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL maxlen_beats: got %0d beats expected %0d", got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL maxlen_beat%0d: got %h expected %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (drop_seen - d0 != 1 || count_drop_o !== 16'(exp_drop) || count_ok_o !== 16'(exp_ok)) begin
            errors++;
            $display("FAIL maxlen_counts: pulses=%0d ok=%0d drop=%0d expected 1 %0d %0d",
                     drop_seen - d0, count_ok_o, count_drop_o, exp_ok, exp_drop);
        end
    endtask

    task automatic test_minlen();
        int d0;
        d0 = drop_seen;
        got_q.delete(); exp_q.delete();
        drive_beat(8'he1, 1'b1, 1'b0);
        idle(3);
        exp_drop++;
        checks++;
        if (got_q.size() != 0 || drop_seen - d0 != 1) begin
            errors++;
            $display("FAIL minlen_short: beats=%0d pulses=%0d expected 0 1", got_q.size(), drop_seen - d0);
        end
        checks++;
        if (state_o !== 2'd0 || count_drop_o !== 16'(exp_drop)) begin
            errors++;
            $display("FAIL minlen_state: state=%0d drop=%0d expected 0 %0d", state_o, count_drop_o, exp_drop);
        end
        exp_q = '{9'h0f1, 9'h1f2};
        drive_beat(8'hf1, 1'b0, 1'b0);
        drive_beat(8'hf2, 1'b1, 1'b0);
        idle(3);
        exp_ok++;
        checks++;
        if (got_q.size() != 2 || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin
            errors++;
            $display("FAIL minlen_two_beat: got %0d beats expected 0f1 1f2", got_q.size());
        end
        checks++;
        if (count_ok_o !== 16'(exp_ok) || drop_seen - d0 != 1) begin
            errors++;
            $display("FAIL minlen_counts: ok=%0d pulses=%0d expected %0d 1", count_ok_o, drop_seen - d0, exp_ok);
        end
    endtask

    task automatic test_stall();
        int d0;
        int b0;
        d0 = drop_seen;
        b0 = drop_bad;
        got_q.delete(); exp_q.delete();
        ready_i = 1'b0;
        drive_beat(8'h71, 1'b0, 1'b0);
        fork
            drive_beat(8'h72, 1'b0, 1'b1);
            begin
                repeat (3) begin
                    @(negedge clock);
                    checks++;
                    if (valid_o !== 1'b1 || data_o !== 8'h71 || drop_o !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_hold: valid=%b data=%h drop=%b expected 1 71 0", valid_o, data_o, drop_o);
                    end
                end
                @(posedge clock);
                #1;
                ready_i = 1'b1;
            end
        join
        drive_beat(8'h73, 1'b1, 1'b0);
        idle(4);
        exp_drop++;
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 9'h071) begin
            errors++;
            $display("FAIL stall_beats: got %0d beats expected only 071", got_q.size());
        end
        checks++;
        if (drop_seen - d0 != 1 || drop_bad != b0 || count_drop_o !== 16'(exp_drop)) begin
            errors++;
            $display("FAIL stall_drop: pulses=%0d with_valid=%0d drop=%0d expected 1 0 %0d",
                     drop_seen - d0, drop_bad - b0, count_drop_o, exp_drop);
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        got_q.delete(); exp_q.delete();
        exp_q = '{9'h081, 9'h182, 9'h091, 9'h192};
        c0 = cycle;
        drive_beat(8'h81, 1'b0, 1'b0);
        drive_beat(8'h82, 1'b1, 1'b0);
        drive_beat(8'h91, 1'b0, 1'b0);
        drive_beat(8'h92, 1'b1, 1'b0);
        checks++;
        if (cycle - c0 != 4) begin
            errors++;
            $display("FAIL b2b_rate: took %0d cycles expected 4", cycle - c0);
        end
        idle(3);
        exp_ok += 2;
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_beats: got %0d beats expected %0d", got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL b2b_beat%0d: got %h expected %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (count_ok_o !== 16'(exp_ok)) begin
            errors++;
            $display("FAIL b2b_count_ok: got %0d expected %0d", count_ok_o, exp_ok);
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        d0 = drop_seen;
        drive_beat(8'h51, 1'b0, 1'b0);
        drive_beat(8'h52, 1'b0, 1'b0);
        reset = 1'b1;
        idle(1);
        @(negedge clock);
        checks++;
        if (valid_o !== 1'b0 || count_ok_o !== 16'd0 || count_drop_o !== 16'd0) begin
            errors++;
            $display("FAIL midreset_state: valid=%b ok=%0d drop=%0d expected 0 0 0", valid_o, count_ok_o, count_drop_o);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_ok = 0;
        exp_drop = 0;
        got_q.delete(); exp_q.delete();
        exp_q = '{9'h061, 9'h062, 9'h163};
        drive_beat(8'h61, 1'b0, 1'b0);
        drive_beat(8'h62, 1'b0, 1'b0);
        drive_beat(8'h63, 1'b1, 1'b0);
        idle(4);
        exp_ok++;
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL midreset_beats: got %0d beats expected %0d", got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL midreset_beat%0d: got %h expected %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (drop_seen != d0 || count_ok_o !== 16'(exp_ok) || count_drop_o !== 16'(exp_drop)) begin
            errors++;
            $display("FAIL midreset_counts: pulses=%0d ok=%0d drop=%0d expected 0 %0d %0d",
                     drop_seen - d0, count_ok_o, count_drop_o, exp_ok, exp_drop);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_error();
        test_maxlen();
        test_minlen();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
